// File: rtl/jc_decoder.sv
// Johnson-code decoder: checks code legality, decodes the state index, and
// tracks sequence continuity with a HUNT/TRACK/LOCKED FSM and a saturating error count.
module jc_decoder #(
  parameter int WIDTH    = 64,
  parameter int LOCK_CNT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          jc_valid,
  input  logic [WIDTH-1:0]              jc_in,
  input  logic                          err_clr,
  output logic                          cnt_valid,
  output logic [$clog2(2*WIDTH)-1:0]    cnt_out,
  output logic                          code_err,
  output logic                          seq_err,
  output logic                          locked,
  output logic [15:0]                   err_cnt
);

  localparam int              IDXW     = $clog2(2*WIDTH);
  localparam logic [IDXW:0]   TWO_W    = (IDXW+1)'(2*WIDTH);
  localparam logic [IDXW-1:0] MAX_IDX  = IDXW'(2*WIDTH-1);
  localparam logic [3:0]      LOCK_RUN = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Legal when the run of ones (bit0=0) or zeros (bit0=1) is packed against the MSB.
  function automatic logic jc_legal(input logic [WIDTH-1:0] c);
    logic ok;
    if (c[0] == 1'b0) begin
      ok = ((c[WIDTH-2:0] & ~c[WIDTH-1:1]) == {(WIDTH-1){1'b0}});
    end else begin
      ok = ((~c[WIDTH-2:0] & c[WIDTH-1:1]) == {(WIDTH-1){1'b0}});
    end
    return ok;
  endfunction

  function automatic logic [IDXW-1:0] jc_index(input logic [WIDTH-1:0] c);
    logic [IDXW:0] pop;
    logic [IDXW:0] idx;
    pop = {(IDXW+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + {{IDXW{1'b0}}, c[i]};
    end
    if (c[0] == 1'b1) begin
      idx = TWO_W - pop;
    end else begin
      idx = pop;
    end
    return idx[IDXW-1:0];
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_legal_q, s2_legal_d;
  logic [IDXW-1:0]  s2_idx_q,   s2_idx_d;

  state_e           state_q,    state_d;
  logic [3:0]       run_q,      run_d;
  logic [IDXW-1:0]  ref_q,      ref_d;

  logic             cnt_valid_q, cnt_valid_d;
  logic [IDXW-1:0]  cnt_out_q,   cnt_out_d;
  logic             code_err_q,  code_err_d;
  logic             seq_err_q,   seq_err_d;
  logic             locked_q,    locked_d;
  logic [15:0]      err_cnt_q,   err_cnt_d;

  logic [IDXW-1:0]  exp_idx;
  logic             in_seq;

  // Input capture and decode pipeline stages.
  always_comb begin
    s1_valid_d = jc_valid;
    if (jc_valid) begin
      s1_data_d = jc_in;
    end else begin
      s1_data_d = s1_data_q;
    end
    s2_valid_d = s1_valid_q;
    s2_legal_d = jc_legal(s1_data_q);
    s2_idx_d   = jc_index(s1_data_q);
  end

  // Sequence tracking FSM and registered output fields.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    ref_d       = ref_q;
    cnt_valid_d = s2_valid_q;
    cnt_out_d   = cnt_out_q;
    code_err_d  = 1'b0;
    seq_err_d   = 1'b0;
    if (ref_q == MAX_IDX) begin
      exp_idx = {IDXW{1'b0}};
    end else begin
      exp_idx = ref_q + {{(IDXW-1){1'b0}}, 1'b1};
    end
    in_seq = (s2_idx_q == exp_idx);

    if (s2_valid_q) begin
      if (!s2_legal_q) begin
        cnt_out_d  = {IDXW{1'b0}};
        code_err_d = 1'b1;
        state_d    = HUNT;
        run_d      = 4'd0;
      end else begin
        cnt_out_d = s2_idx_q;
        ref_d     = s2_idx_q;
        case (state_q)
          HUNT: begin
            state_d = TRACK;
            run_d   = 4'd1;
          end
          TRACK: begin
            if (in_seq) begin
              run_d = run_q + 4'd1;
              if ((run_q + 4'd1) == LOCK_RUN) begin
                state_d = LOCKED;
              end else begin
                state_d = TRACK;
              end
            end else begin
              seq_err_d = 1'b1;
              run_d     = 4'd1;
            end
          end
          LOCKED: begin
            if (in_seq) begin
              state_d = LOCKED;
            end else begin
              seq_err_d = 1'b1;
              state_d   = TRACK;
              run_d     = 4'd1;
            end
          end
          default: begin
            state_d = HUNT;
            run_d   = 4'd0;
          end
        endcase
      end
    end else begin
      cnt_out_d = cnt_out_q;
    end

    locked_d = (state_d == LOCKED);

    // Clear takes priority over a coincident increment.
    if (err_clr) begin
      err_cnt_d = 16'd0;
    end else if ((code_err_d || seq_err_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {WIDTH{1'b0}};
      s2_valid_q  <= 1'b0;
      s2_legal_q  <= 1'b0;
      s2_idx_q    <= {IDXW{1'b0}};
      state_q     <= HUNT;
      run_q       <= 4'd0;
      ref_q       <= {IDXW{1'b0}};
      cnt_valid_q <= 1'b0;
      cnt_out_q   <= {IDXW{1'b0}};
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_legal_q  <= s2_legal_d;
      s2_idx_q    <= s2_idx_d;
      state_q     <= state_d;
      run_q       <= run_d;
      ref_q       <= ref_d;
      cnt_valid_q <= cnt_valid_d;
      cnt_out_q   <= cnt_out_d;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cnt_valid = cnt_valid_q;
  assign cnt_out   = cnt_out_q;
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jc_decoder.sv
// Directed bench for jc_decoder at WIDTH=64: table vectors plus generated sweeps,
// each sample's expected outputs compared two edges after it is driven.
module tb_jc_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        jc_valid;
  logic [63:0] jc_in;
  logic        err_clr;
  logic        cnt_valid;
  logic [6:0]  cnt_out;
  logic        code_err;
  logic        seq_err;
  logic        locked;
  logic [15:0] err_cnt;

  int npass  = 0;
  int ntotal = 0;

  jc_decoder #(.WIDTH(64), .LOCK_CNT(4)) dut (
    .clk(clk), .rst(rst), .jc_valid(jc_valid), .jc_in(jc_in), .err_clr(err_clr),
    .cnt_valid(cnt_valid), .cnt_out(cnt_out), .code_err(code_err),
    .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    logic        v;
    logic [63:0] jc;
    logic        clr;
    logic        chk;
    logic        ev;
    logic [6:0]  ecnt;
    logic        ecode;
    logic        eseq;
    logic        elock;
    logic [15:0] eerr;
  } vec_t;

  vec_t expq[$];

  function automatic logic [63:0] jc_code(input int k);
    logic [63:0] c;
    c = 64'd0;
    for (int b = 0; b < 64; b++) begin
      if (k <= 64) c[b] = (b >= 64 - k);
      else         c[b] = (b < 128 - k);
    end
    return c;
  endfunction

  function automatic vec_t mk(bit r, logic v, logic [63:0] c, logic clr, logic chk,
                              logic ev, logic [6:0] cnt, logic ce, logic se,
                              logic lk, logic [15:0] ec);
    vec_t t;
    t.do_rst = r; t.v = v; t.jc = c; t.clr = clr; t.chk = chk; t.ev = ev;
    t.ecnt = cnt; t.ecode = ce; t.eseq = se; t.elock = lk; t.eerr = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    vec_t e;
    jc_valid = t.v;
    jc_in    = t.jc;
    err_clr  = t.clr;
    expq.push_back(t);
    tick();
    if (expq.size() == 3) begin
      e = expq.pop_front();
      check("cnt_valid", 64'(cnt_valid), 64'(e.ev));
      if (e.chk) begin
        check("cnt_out",  64'(cnt_out),  64'(e.ecnt));
        check("code_err", 64'(code_err), 64'(e.ecode));
        check("seq_err",  64'(seq_err),  64'(e.eseq));
        check("locked",   64'(locked),   64'(e.elock));
        check("err_cnt",  64'(err_cnt),  64'(e.eerr));
      end
    end else begin
      check("no_stale_valid", 64'(cnt_valid), 64'd0);
    end
  endtask

  task automatic do_reset(input logic v_during);
    rst      = 1'b1;
    jc_valid = v_during;
    jc_in    = jc_code(56);
    err_clr  = 1'b0;
    tick();
    check("rst_cnt_valid", 64'(cnt_valid), 64'd0);
    check("rst_cnt_out",   64'(cnt_out),   64'd0);
    check("rst_code_err",  64'(code_err),  64'd0);
    check("rst_seq_err",   64'(seq_err),   64'd0);
    check("rst_locked",    64'(locked),    64'd0);
    check("rst_err_cnt",   64'(err_cnt),   64'd0);
    rst = 1'b0;
    expq.delete();
  endtask

  vec_t tbl[$];
  int   e_model;

  initial begin
    // Illegal code while locked, then HUNT re-entry without seq_err.
    tbl.push_back(mk(0, 1'b1, 64'h5,        1'b0, 1'b1, 1'b1, 7'd0,  1'b1, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(50),  1'b0, 1'b1, 1'b1, 7'd50, 1'b0, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(51),  1'b0, 1'b1, 1'b1, 7'd51, 1'b0, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(52),  1'b0, 1'b1, 1'b1, 7'd52, 1'b0, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(53),  1'b0, 1'b1, 1'b1, 7'd53, 1'b0, 1'b0, 1'b1, 16'd1));
    // In flight when reset hits; must never appear.
    tbl.push_back(mk(0, 1'b1, jc_code(54),  1'b0, 1'b1, 1'b1, 7'd54, 1'b0, 1'b0, 1'b1, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(55),  1'b0, 1'b1, 1'b1, 7'd55, 1'b0, 1'b0, 1'b1, 16'd1));
    // Relock after reset, then skip 3 -> 10 and relock at 13.
    tbl.push_back(mk(1, 1'b1, jc_code(0),   1'b0, 1'b1, 1'b1, 7'd0,  1'b0, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(0, 1'b1, jc_code(1),   1'b0, 1'b1, 1'b1, 7'd1,  1'b0, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(0, 1'b1, jc_code(2),   1'b0, 1'b1, 1'b1, 7'd2,  1'b0, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(0, 1'b1, jc_code(3),   1'b0, 1'b1, 1'b1, 7'd3,  1'b0, 1'b0, 1'b1, 16'd0));
    tbl.push_back(mk(0, 1'b1, jc_code(10),  1'b0, 1'b1, 1'b1, 7'd10, 1'b0, 1'b1, 1'b0, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(11),  1'b0, 1'b1, 1'b1, 7'd11, 1'b0, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(12),  1'b0, 1'b1, 1'b1, 7'd12, 1'b0, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(0, 1'b1, jc_code(13),  1'b0, 1'b1, 1'b1, 7'd13, 1'b0, 1'b0, 1'b1, 16'd1));

    rst = 1'b1; jc_valid = 1'b0; jc_in = 64'd0; err_clr = 1'b0;
    tick();
    do_reset(1'b0);

    // Locking sweep across the 127 -> 0 wrap.
    for (int k = 0; k < 130; k++) begin
      drive(mk(0, 1'b1, jc_code(k % 128), 1'b0, 1'b1, 1'b1, 7'(k % 128),
               1'b0, 1'b0, (k >= 3), 16'd0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset(1'b1);
      drive(tbl[i]);
    end

    // Gapped sweep continuing from 14, wrapping past 127.
    for (int n = 0; n < 120; n++) begin
      drive(mk(0, 1'b1, jc_code((14 + n) % 128), 1'b0, 1'b1, 1'b1, 7'((14 + n) % 128),
               1'b0, 1'b0, 1'b1, 16'd1));
      drive(mk(0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 7'((14 + n) % 128),
               1'b0, 1'b0, 1'b1, 16'd1));
    end

    // Saturation of the error counter.
    e_model = 1;
    for (int n = 0; n < 65540; n++) begin
      if (e_model < 65535) e_model++;
      drive(mk(0, 1'b1, 64'h5, 1'b0, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 16'(e_model)));
    end

    // Clear coincident with an errored output wins.
    drive(mk(0, 1'b1, 64'h5,       1'b0, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 16'd0));
    drive(mk(0, 1'b1, 64'h5,       1'b0, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 16'd1));
    drive(mk(0, 1'b1, 64'h5,       1'b1, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 16'd2));
    drive(mk(0, 1'b1, jc_code(0),  1'b0, 1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 16'd2));
    drive(mk(0, 1'b0, 64'd0,       1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd2));
    drive(mk(0, 1'b0, 64'd0,       1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd2));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
